uart_word_tx: RTL

- Memory-mapped 32-bit word transmitter on the same slave-register bus as the existing register peripherals (addr/rd_en/wr_en/dataIn/dataOut).
- Downstream consumer of processed register results: software writes a 32-bit word, and the block buffers it in a small FIFO.
- Each word is serialised as four 8N1 UART bytes, least-significant byte first.
- Provides status, control, a sent-word counter and a programmable baud divisor.

---
 rtl/uart_word_tx_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_word_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_tx_pkg.sv
// Shared constants, register map, FSM encoding and reset divisor calculation for uart_word_tx.
// Latency: none (package only).
// Backpressure: n/a.
package uart_word_tx_pkg;

    // Register select values on the slave bus
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_CNT  = 2'd2;
    localparam logic [1:0] ADDR_DIV  = 2'd3;

    // Status register bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    // Control register bit positions (OVF_CLR is write-only, never stored)
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_OVF_CLR = 2;

    // Smallest divisor the bit timer can honour
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clocks per bit, rounded to nearest
    function automatic logic [15:0] div_rst(input int unsigned clk_hz, input int unsigned baud);
        logic [31:0] q;
        q = (clk_hz + baud / 2) / baud;
        return q[15:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata shows the head whenever empty is low.
// Latency: a push is visible on rdata/empty the cycle after the write edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO can still take a word if the head leaves on the same edge
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since empty gates every read
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_word_tx.sv
// Memory-mapped word transmitter: buffers 32-bit words and sends each as four 8N1 bytes, LSB byte first.
// Latency: write into an empty FIFO with enable set -> tx falls one clock later; one word = 40*bit_div clocks.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flagged in the sticky overflow bit.
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        tx,
    output logic        irq
);
    localparam logic [15:0] DIV_RST = div_rst(CLK_HZ, BAUD);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;

    // Bus-side registers
    logic        enable;
    logic        irq_en;
    logic        overflow;
    logic [31:0] sent_cnt;
    logic [15:0] divisor;

    // FIFO interface
    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   count_ext;
    logic [3:0]    count_sat;

    // Serialiser state and its next values
    tx_state_t   state,    state_nxt;
    logic [31:0] shreg,    shreg_nxt;
    logic [15:0] bit_div,  bit_div_nxt;
    logic [15:0] baud_cnt, baud_nxt;
    logic [2:0]  bit_idx,  bit_nxt;
    logic [1:0]  byte_idx, byte_nxt;
    logic        tx_nxt;
    logic        bit_done;
    logic        sent_inc;
    logic        busy;

    logic        unused_data_hi;
    assign unused_data_hi = ^dataIn[31:16];

    assign busy      = (state != IDLE);
    assign fifo_push = wr_en & (addr == ADDR_DATA);
    assign count_ext = 32'(fifo_count);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (dataIn),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Serialiser state register; reset abandons any frame and parks tx high
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_div  <= DIV_RST;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_div  <= bit_div_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            tx       <= tx_nxt;
        end
    end

    // Next-state logic: each bit lasts bit_div clocks; shreg shifts once per data bit so the next byte lands in [7:0]
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_div_nxt = bit_div;
        baud_nxt    = baud_cnt;
        bit_nxt     = bit_idx;
        byte_nxt    = byte_idx;
        tx_nxt      = tx;
        fifo_pop    = 1'b0;
        sent_inc    = 1'b0;
        bit_done    = (baud_cnt == bit_div - 16'd1);
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    shreg_nxt   = fifo_rdata;
                    bit_div_nxt = divisor;
                    baud_nxt    = '0;
                    byte_nxt    = '0;
                    tx_nxt      = 1'b0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shreg[0];
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_nxt  = '0;
                    shreg_nxt = {1'b0, shreg[31:1]};
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        tx_nxt  = shreg[1];
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_nxt = '0;
                    if (byte_idx != 2'd3) begin
                        byte_nxt  = byte_idx + 2'd1;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        sent_inc  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus register writes, sticky overflow, sent counter (clear beats increment) and registered irq
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            sent_cnt <= '0;
            divisor  <= DIV_RST;
            irq      <= 1'b0;
        end else begin
            if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
            if (wr_en && addr == ADDR_CTRL) begin
                enable <= dataIn[CTRL_EN];
                irq_en <= dataIn[CTRL_IRQ_EN];
                if (dataIn[CTRL_OVF_CLR]) overflow <= 1'b0;
            end
            if (wr_en && addr == ADDR_CNT)  sent_cnt <= '0;
            else if (sent_inc)              sent_cnt <= sent_cnt + 32'd1;
            if (wr_en && addr == ADDR_DIV)
                divisor <= (dataIn[15:0] < DIV_MIN) ? DIV_MIN : dataIn[15:0];
            irq <= irq_en & fifo_empty & ~busy;
        end
    end

    // Combinational read mux, zero when not reading
    always_comb begin
        dataOut = '0;
        if (rd_en) begin
            case (addr)
                ADDR_DATA: begin
                    dataOut[ST_BUSY]                 = busy;
                    dataOut[ST_FULL]                 = fifo_full;
                    dataOut[ST_EMPTY]                = fifo_empty;
                    dataOut[ST_OVF]                  = overflow;
                    dataOut[ST_CNT_LSB +: 4]         = count_sat;
                end
                ADDR_CTRL: dataOut = {30'b0, irq_en, enable};
                ADDR_CNT:  dataOut = sent_cnt;
                default:   dataOut = {16'b0, divisor};
            endcase
        end
    end

endmodule
